// File: rtl/issue_pkg.sv
// Shared types and constants for the issue unit: result-bus owner encoding,
// default unit latencies and the depth of the CDB reservation table.
package issue_pkg;

    typedef enum logic [1:0] {
        OWN_INT  = 2'd0,
        OWN_MEM  = 2'd1,
        OWN_MULT = 2'd2,
        OWN_DIV  = 2'd3
    } owner_e;

    localparam int TABLE_DEPTH  = 7;
    localparam int SLOT_W       = $clog2(TABLE_DEPTH + 1);
    localparam int N_UNITS      = 4;

    localparam int DEF_INT_LAT  = 1;
    localparam int DEF_MEM_LAT  = 3;
    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 7;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } slot_t;

    function automatic slot_t make_slot(input logic valid, input owner_e owner);
        slot_t s;
        s.valid = valid;
        s.owner = owner;
        return s;
    endfunction

endpackage

// File: rtl/issue_unit_slot_table.sv
// cdb_slot_table: shifting CDB reservation table. Slot k describes the result
// bus k cycles from now; slot 1 drains into the registered CDB outputs.
module cdb_slot_table
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rsv_valid,
    input  logic [SLOT_W-1:0] i_rsv_slot,
    input  owner_e            i_rsv_owner,
    input  logic [SLOT_W-1:0] i_look_slot [N_UNITS],
    output logic              o_look_busy [N_UNITS],
    output logic              o_cdb_valid,
    output owner_e            o_cdb_owner
);

    slot_t r_slot [1:TABLE_DEPTH];
    slot_t w_rsv;

    assign w_rsv = make_slot(1'b1, i_rsv_owner);

    // A reservation for slot L lands in slot L-1 after this edge's shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cdb_valid <= 1'b0;
            o_cdb_owner <= OWN_INT;
            for (int k = 1; k <= TABLE_DEPTH; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            if (i_rsv_valid && i_rsv_slot == SLOT_W'(1)) begin
                o_cdb_valid <= 1'b1;
                o_cdb_owner <= i_rsv_owner;
            end else begin
                o_cdb_valid <= r_slot[1].valid;
                o_cdb_owner <= r_slot[1].owner;
            end
            for (int k = 1; k < TABLE_DEPTH; k++) begin
                if (i_rsv_valid && i_rsv_slot == SLOT_W'(k + 1)) begin
                    r_slot[k] <= w_rsv;
                end else begin
                    r_slot[k] <= r_slot[k + 1];
                end
            end
            r_slot[TABLE_DEPTH] <= '0;
        end
    end

    always_comb begin
        for (int n = 0; n < N_UNITS; n++) begin
            o_look_busy[n] = 1'b0;
            for (int k = 1; k <= TABLE_DEPTH; k++) begin
                if (i_look_slot[n] == SLOT_W'(k)) begin
                    o_look_busy[n] = r_slot[k].valid;
                end
            end
        end
    end

endmodule

// File: rtl/issue_unit.sv
// issue_unit: single-issue arbiter over int/mem/mult/div queues with a
// collision-free CDB reservation table. ISSUE_RR_EN enables int/mem round-robin.
module issue_unit
    import issue_pkg::*;
#(
    parameter int INT_LAT  = DEF_INT_LAT,
    parameter int MEM_LAT  = DEF_MEM_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_ready,
    input  logic       mem_ready,
    input  logic       mult_ready,
    input  logic       div_ready,
    output logic       int_issue,
    output logic       mem_issue,
    output logic       mult_issue,
    output logic       div_issue,
    output logic       cdb_valid,
    output logic [1:0] cdb_owner,
    output logic       div_busy
);

    logic [SLOT_W-1:0] w_look_slot [N_UNITS];
    logic              w_look_busy [N_UNITS];
    logic              w_elig_int, w_elig_mem, w_elig_mult, w_elig_div;
    logic              w_gnt_int, w_gnt_mem, w_gnt_mult, w_gnt_div;
    logic              w_rsv_valid;
    logic [SLOT_W-1:0] w_rsv_slot;
    owner_e            w_rsv_owner;
    owner_e            w_cdb_owner;
    logic [2:0]        r_div_cnt;

    assign w_look_slot[OWN_INT]  = SLOT_W'(INT_LAT);
    assign w_look_slot[OWN_MEM]  = SLOT_W'(MEM_LAT);
    assign w_look_slot[OWN_MULT] = SLOT_W'(MULT_LAT);
    assign w_look_slot[OWN_DIV]  = SLOT_W'(DIV_LAT);

    assign div_busy    = (r_div_cnt != 3'd0);
    assign w_elig_int  = int_ready  && !w_look_busy[OWN_INT];
    assign w_elig_mem  = mem_ready  && !w_look_busy[OWN_MEM];
    assign w_elig_mult = mult_ready && !w_look_busy[OWN_MULT];
    assign w_elig_div  = div_ready  && !w_look_busy[OWN_DIV] && !div_busy;

`ifdef ISSUE_RR_EN
    logic r_rr_mem;  // 1 = mem favoured on the next int/mem tie
`endif

    always_comb begin
        w_gnt_int  = 1'b0;
        w_gnt_mem  = 1'b0;
        w_gnt_mult = 1'b0;
        w_gnt_div  = 1'b0;
        if (!rst) begin
            if (w_elig_div) begin
                w_gnt_div = 1'b1;
            end else if (w_elig_mult) begin
                w_gnt_mult = 1'b1;
            end else if (w_elig_int && w_elig_mem) begin
`ifdef ISSUE_RR_EN
                w_gnt_int = !r_rr_mem;
                w_gnt_mem = r_rr_mem;
`else
                w_gnt_int = 1'b1;
`endif
            end else begin
                w_gnt_int = w_elig_int;
                w_gnt_mem = w_elig_mem;
            end
        end
    end

    assign int_issue  = w_gnt_int;
    assign mem_issue  = w_gnt_mem;
    assign mult_issue = w_gnt_mult;
    assign div_issue  = w_gnt_div;

    always_comb begin
        w_rsv_valid = w_gnt_int | w_gnt_mem | w_gnt_mult | w_gnt_div;
        w_rsv_slot  = w_look_slot[OWN_INT];
        w_rsv_owner = OWN_INT;
        if (w_gnt_div) begin
            w_rsv_slot  = w_look_slot[OWN_DIV];
            w_rsv_owner = OWN_DIV;
        end else if (w_gnt_mult) begin
            w_rsv_slot  = w_look_slot[OWN_MULT];
            w_rsv_owner = OWN_MULT;
        end else if (w_gnt_mem) begin
            w_rsv_slot  = w_look_slot[OWN_MEM];
            w_rsv_owner = OWN_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= 3'd0;
        end else if (w_gnt_div) begin
            r_div_cnt <= 3'(DIV_LAT - 1);
        end else if (r_div_cnt != 3'd0) begin
            r_div_cnt <= r_div_cnt - 3'd1;
        end
    end

`ifdef ISSUE_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_mem <= 1'b0;
        end else if (w_gnt_int) begin
            r_rr_mem <= 1'b1;
        end else if (w_gnt_mem) begin
            r_rr_mem <= 1'b0;
        end
    end
`endif

    cdb_slot_table u_table (
        .clk         (clk),
        .rst         (rst),
        .i_rsv_valid (w_rsv_valid),
        .i_rsv_slot  (w_rsv_slot),
        .i_rsv_owner (w_rsv_owner),
        .i_look_slot (w_look_slot),
        .o_look_busy (w_look_busy),
        .o_cdb_valid (cdb_valid),
        .o_cdb_owner (w_cdb_owner)
    );

    assign cdb_owner = w_cdb_owner;

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 SHALL have parameter INT_LAT, 1, issue-to-CDB latency of integer unit.
REQ-002 SHALL have parameter MEM_LAT, 3, issue-to-CDB latency of load/store unit.
REQ-003 SHALL have parameter MULT_LAT, 4, issue-to-CDB latency of pipelined multiplier.
REQ-004 SHALL have parameter DIV_LAT, 7, issue-to-CDB latency of non-pipelined divider; all latencies 1..7.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports int_ready, mem_ready, mult_ready, div_ready  input  1 each  queue holds an operand-ready entry.
REQ-008 SHALL have ports int_issue, mem_issue, mult_issue, div_issue  output  1 each  combinational grant; queue pops on it.
REQ-009 SHALL have port cdb_valid  output  1  registered, a result is on the CDB this cycle.
REQ-010 SHALL have port cdb_owner  output  2  registered, unit driving CDB (0 int, 1 mem, 2 mult, 3 div).
REQ-011 SHALL have port div_busy  output  1  divider occupied.

Function
REQ-012 SHALL grant at most one issue per cycle.
REQ-013 SHALL keep a 7-entry reservation table; entry k (1..7) holds valid + 2-bit owner for the CDB in cycle now+k.
REQ-014 SHALL shift the table down one entry every clock; entry 1 loads into cdb_valid/cdb_owner; entry 7 refills empty.
REQ-015 SHALL consider a unit eligible only when its ready is high and entry[its latency] is empty.
REQ-016 SHALL write entry[L] with the owner of the unit issued in cycle t; cdb_valid=1, cdb_owner=unit during cycle t+L exactly.
REQ-017 SHALL block div eligibility while div_busy; div issue loads a counter with DIV_LAT-1, decremented each cycle to 0; div_busy = counter != 0.
REQ-018 SHALL prioritise div > mult > {int, mem}.
REQ-019 SHALL arbitrate int vs mem per REQ-026 when both eligible and no higher grant.
REQ-020 SHALL issue nothing and change no state other than shifting when no unit is eligible.
REQ-021 SHALL never produce two results on the CDB in one cycle (collision-free by construction).

Reset
REQ-022 SHALL on rst clear all reservation entries, div counter, and the round-robin pointer (int favoured).
REQ-023 SHALL drive cdb_valid=0, cdb_owner=0, div_busy=0 while rst high; issue outputs 0 while rst high.
REQ-024 SHALL discard in-flight reservations on reset mid-operation; first grant possible the cycle after rst deasserts.

Configuration
REQ-025 SHALL honour macro ISSUE_RR_EN.
REQ-026 SHALL with ISSUE_RR_EN defined use a 1-bit pointer: grant the favoured of int/mem, then favour the other; pointer unchanged without an int/mem grant. Without it: fixed int > mem, no pointer.

Structure
REQ-027 SHALL place owner enum (INT, MEM, MULT, DIV), latency defaults and table depth constant (7) in shared package issue_pkg.
REQ-028 SHALL implement the table as sub-module cdb_slot_table (shift, reserve port, slot-lookup outputs); arbitration stays in issue_unit.

Verification
REQ-029 SHALL check: int_ready only at cycle 2 -> int_issue cycle 2, cdb_valid=1 owner=0 cycle 3, 0 otherwise.
REQ-030 SHALL check: div_ready held high from cycle 0 -> div_issue cycles 0 and 7 only; div_busy high cycles 1-6; cdb owner=3 cycles 7 and 14.
REQ-031 SHALL check: mult issued cycle 0, mem_ready cycle 1 -> mem blocked cycle 1 (entry 3 busy), issues cycle 2; CDB owner 2 cycle 4, owner 1 cycle 5.
REQ-032 SHALL check: int and mem ready continuously, ISSUE_RR_EN -> grants int, mem, int, mem cycles 0-3; without macro -> int every cycle.
REQ-033 SHALL check: all four ready at cycle 0 -> div only; mult cycle 1; int/mem from cycle 2; no cycle with more than one grant.
REQ-034 SHALL check: rst pulsed cycle 3 after div issue cycle 0 -> div_busy, cdb_valid 0 from cycle 3; no owner-3 result at cycle 7.
